pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the 16-bit combinational shifter.
- Width is generic, with one register stage per shift level and a valid/ready handshake on both sides.
- Adds a rotate-right mode and a zero-result flag.
- Intended as the execute-stage shifter for the wider datapath, where shift logic must be retimed across cycles.

Parameters:
- WIDTH, 16, data width; must be a power of two, and 4 or greater.
- CNT_W, $clog2(WIDTH), shift-count width; this equals the number of pipeline stages.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input operand valid
- in_ready  output  1  block accepts the input this cycle
- in_data  input  WIDTH  operand
- in_cnt  input  CNT_W  shift amount, 0..WIDTH-1
- in_op  input  3  operation (see Behaviour)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data is all zeros
- out_err  output  1  in_op was an illegal encoding

Behaviour:
- Op encoding:
  - 000 ROL (rotate left)
  - 001 SLL (shift left logical)
  - 010 SRA (shift right arithmetic)
  - 011 SRL (shift right logical)
  - 100 ROR (rotate right)
  - 101..111 are illegal: data passes through unshifted and err=1.
- Fill rules:
  - SLL fills 0 from the LSB side.
  - SRL fills 0 from the MSB side.
  - SRA fills with in_data[WIDTH-1] of the original operand. This sign bit is captured at stage 0 and carried through all stages, not re-sampled per stage.
- Pipeline structure:
  - Stages 0..CNT_W-1. Stage k conditionally shifts by 2^k when cnt[k]=1.
  - Each stage register holds: valid, data, cnt, op, sign, err.
  - Stage k's output is registered. out_* are driven directly from the last stage register.
- Latency and throughput:
  - Latency is exactly CNT_W cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall.
  - Throughput is one operation per cycle.
- Flow control (global stall):
  - adv = !out_valid | out_ready.
  - in_ready = adv.
  - When adv=1, every stage loads from its predecessor. Stage 0 loads valid = in_valid.
  - When adv=0, all stage registers hold.
  - Bubbles are not collapsed, so a stalled pipeline holds empty slots.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_zero and out_err must be stable.
- out_zero is computed combinationally from the final register: ~|out_data.
- Count rules:
  - cnt=0 yields out_data = in_data for every legal op.
  - Counts are always < WIDTH, so there is no over-shift case.
- Reset:
  - rst=1 clears all stage valid bits on the next edge. Any in-flight operations are discarded.
  - After reset: out_valid=0, out_err=0, out_data=0, out_zero=1. in_ready is 1 once out_valid=0.
  - Data registers also reset to 0.
- Simultaneous events:
  - If rst and in_valid are both high, reset wins: nothing is accepted.
  - out_ready=1 together with in_valid=1 on a full pipeline: the output retires and the input is accepted in the same cycle.
- Illegal op: data passes unchanged through all stages and err=1 at the output. The result is still delivered through the handshake.

Decomposition:
- Package shifter_pkg holds:
  - op localparams: OP_ROL, OP_SLL, OP_SRA, OP_SRL, OP_ROR.
  - the OP_W=3 constant.
  - a function is_legal_op(op).
- One sub-module, shift_stage_reg, parametrised by WIDTH, CNT_W and STAGE (shift amount = 1<<STAGE).
  - Contains the combinational mux for the five ops and the stage register with hold/advance.
  - The top level is a generate loop of CNT_W instances plus the handshake logic.

Test Plan:
All scenarios use WIDTH=16, so CNT_W=4.
- ROL 0x8001, cnt=1, out_ready=1 -> out_data=0x0003, out_valid rises exactly 4 cycles after acceptance, zero=0, err=0.
- SRA 0x8000, cnt=15 -> 0xFFFF. SRL 0x8000, cnt=15 -> 0x0001. SLL 0x0001, cnt=15 -> 0x8000. ROR 0x0001, cnt=4 -> 0x1000.
- Zero and pass-through cases:
  - SLL 0x00F0, cnt=12 -> 0x0000 with out_zero=1.
  - Any legal op with cnt=0 on 0xA5C3 -> 0xA5C3.
  - op=110 on 0x1234, cnt=3 -> 0x1234 with out_err=1.
- Backpressure:
  - Issue 6 back-to-back ops (ROL 0x0001 by 0..5).
  - Hold out_ready=0 for 3 cycles after the first out_valid.
  - Expect: in_ready=0 during the stall, out_data held stable, results 0x0001, 0x0002, 0x0004, 0x0008, 0x0010, 0x0020 in order, with no loss or duplication.
- Reset mid-operation:
  - Accept 3 ops, then assert rst for 1 cycle at cycle 2.
  - Expect: out_valid=0 and out_zero=1 next cycle, and none of the 3 results ever appear.
  - A new op accepted after reset completes with normal 4-cycle latency.
- Randomised soak of 10k ops with random stalls, compared against a reference model for all five legal ops and illegal encodings.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared op encodings and helpers for the pipelined barrel shifter.
// Anything that decodes an op imports this package.
package shifter_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ROL = 3'b000;
  localparam logic [OP_W-1:0] OP_SLL = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA = 3'b010;
  localparam logic [OP_W-1:0] OP_SRL = 3'b011;
  localparam logic [OP_W-1:0] OP_ROR = 3'b100;

  // Encodings above ROR are reserved; such operands pass through untouched.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_stage_reg.sv
// One shifter pipeline level: shift by 2**STAGE when cnt[STAGE] is set, then register.
// All levels share one advance strobe, so a stall freezes the whole pipe.
module shift_stage_reg
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH),
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [CNT_W-1:0] prev_cnt,
  input  logic [OP_W-1:0]  prev_op,
  input  logic             prev_sign,
  input  logic             prev_err,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic [OP_W-1:0]  op,
  output logic             sign,
  output logic             err
);

  localparam int SH = 1 << STAGE;

  logic [WIDTH-1:0] shifted;

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    shifted = prev_data;
    if (prev_cnt[STAGE]) begin
      case (prev_op)
        OP_ROL:  shifted = {prev_data[WIDTH-SH-1:0], prev_data[WIDTH-1:WIDTH-SH]};
        OP_SLL:  shifted = {prev_data[WIDTH-SH-1:0], {SH{1'b0}}};
        // Fill from the sign captured at stage 0, not from this stage's MSB.
        OP_SRA:  shifted = {{SH{prev_sign}}, prev_data[WIDTH-1:SH]};
        OP_SRL:  shifted = {{SH{1'b0}}, prev_data[WIDTH-1:SH]};
        OP_ROR:  shifted = {prev_data[SH-1:0], prev_data[WIDTH-1:SH]};
        default: shifted = prev_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: data/control registers are cleared too, so out_data reads 0 after reset.
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
      op    <= OP_ROL;
      sign  <= 1'b0;
      err   <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      valid <= prev_valid;
      data  <= shifted;
      cnt   <= prev_cnt;
      op    <= prev_op;
      sign  <= prev_sign;
      err   <= prev_err;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: CNT_W registered shift levels behind a valid/ready pair.
// A single global stall holds every level; bubbles are not collapsed.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  // Index 0 is the input operand; index k+1 is the register of level k.
  logic             valid_s [CNT_W+1];
  logic [WIDTH-1:0] data_s  [CNT_W+1];
  logic [CNT_W-1:0] cnt_s   [CNT_W+1];
  logic [OP_W-1:0]  op_s    [CNT_W+1];
  logic             sign_s  [CNT_W+1];
  logic             err_s   [CNT_W+1];

  logic adv;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign cnt_s[0]   = in_cnt;
  assign op_s[0]    = in_op;
  assign sign_s[0]  = in_data[WIDTH-1];
  assign err_s[0]   = !is_legal_op(in_op);

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    shift_stage_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .STAGE (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .prev_valid (valid_s[k]),
      .prev_data  (data_s[k]),
      .prev_cnt   (cnt_s[k]),
      .prev_op    (op_s[k]),
      .prev_sign  (sign_s[k]),
      .prev_err   (err_s[k]),
      .valid      (valid_s[k+1]),
      .data       (data_s[k+1]),
      .cnt        (cnt_s[k+1]),
      .op         (op_s[k+1]),
      .sign       (sign_s[k+1]),
      .err        (err_s[k+1])
    );
  end

  // The whole pipe moves unless a finished result is waiting on downstream.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign out_valid = valid_s[CNT_W];
  assign out_data  = data_s[CNT_W];
  assign out_err   = err_s[CNT_W];
  assign out_zero  = ~|out_data;

  // Count, op and sign are spent by the time they reach the last register.
  logic unused_tail;
  assign unused_tail = ^{cnt_s[CNT_W], op_s[CNT_W], sign_s[CNT_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=16): directed cases,
// backpressure, mid-flight reset and a randomised soak against an arithmetic model.
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_err;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
    int               acc_cycle;
    bit               lat_chk;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cycle      = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: driven by the test
  bit   lat_mode   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Shift semantics from plain integer arithmetic on a 32-bit copy of the operand.
  function automatic logic [WIDTH-1:0] model(input logic [OP_W-1:0] op,
                                             input logic [WIDTH-1:0] d, input int c);
    int unsigned x;
    int          s;
    x = {16'b0, d};
    s = {{16{d[15]}}, d};
    case (op)
      3'd0:    return 16'((x << c) | (x >> (WIDTH - c)));
      3'd1:    return 16'(x << c);
      3'd2:    return 16'(s >>> c);
      3'd3:    return 16'(x >> c);
      3'd4:    return 16'((x >> c) | (x << (WIDTH - c)));
      default: return d;
    endcase
  endfunction

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (ready_mode == 0)      out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 99) < 65);
  end

  // Monitor: samples 3 time units after the falling edge, well clear of the rising edge.
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic             held_zero;
  logic             held_err;
  exp_t             got;

  always begin
    @(negedge clk);
    #3;
    if (prev_stall) begin
      check("hold_data", 32'(out_data), 32'(held_data));
      check("hold_zero", 32'(out_zero), 32'(held_zero));
      check("hold_err", 32'(out_err), 32'(held_err));
    end
    prev_stall = 1'b0;
    if (!rst && out_valid) begin
      if (!out_ready) begin
        check("in_ready_during_stall", 32'(in_ready), 32'd0);
        prev_stall = 1'b1;
        held_data  = out_data;
        held_zero  = out_zero;
        held_err   = out_err;
      end else if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=no output (cycle %0d)", out_data, cycle);
      end else begin
        got = sb.pop_front();
        check("out_data", 32'(out_data), 32'(got.data));
        check("out_zero", 32'(out_zero), 32'(got.zero));
        check("out_err", 32'(out_err), 32'(got.err));
        if (got.lat_chk) check("latency", 32'(cycle - got.acc_cycle), 32'(CNT_W));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance with in_valid still high.
  task automatic send(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] d,
                      input logic [CNT_W-1:0] c, input logic [WIDTH-1:0] exp_data,
                      input logic exp_err);
    exp_t e;
    int   waited = 0;
    bit   done   = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_cnt   = c;
    e.data    = exp_data;
    e.zero    = (exp_data == '0);
    e.err     = exp_err;
    e.lat_chk = lat_mode;
    while (!done) begin
      #3;
      if (in_ready && !rst) begin
        e.acc_cycle = cycle;
        sb.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
      waited++;
      if (!done && waited > 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=in_ready low required=accept within 100 cycles");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] c;
    int               t;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_zero", 32'(out_zero), 32'd1);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with the output always ready: latency must be exactly CNT_W.
    lat_mode = 1'b1;
    send(OP_ROL, 16'h8001, 4'd1,  16'h0003, 1'b0);
    send(OP_SRA, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
    send(OP_SRL, 16'h8000, 4'd15, 16'h0001, 1'b0);
    send(OP_SLL, 16'h0001, 4'd15, 16'h8000, 1'b0);
    send(OP_ROR, 16'h0001, 4'd4,  16'h1000, 1'b0);
    send(OP_SLL, 16'h00F0, 4'd12, 16'h0000, 1'b0);
    send(OP_SRA, 16'h7FF0, 4'd4,  16'h07FF, 1'b0);
    for (int k = 0; k < 5; k++) send(3'(k), 16'hA5C3, 4'd0, 16'hA5C3, 1'b0);
    send(3'b110, 16'h1234, 4'd3, 16'h1234, 1'b1);
    send(3'b101, 16'h0000, 4'd7, 16'h0000, 1'b1);
    idle(8);

    // Backpressure: six back-to-back rotates, 3-cycle stall after the first result.
    lat_mode   = 1'b0;
    ready_mode = 2;
    out_ready  = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(OP_ROL, 16'h0001, i[3:0], 16'(1 << i), 1'b0);
        idle(1);
      end
      begin
        t = 0;
        do begin
          @(negedge clk);
          #3;
          t++;
        end while (!out_valid && t < 50);
        if (t >= 50) check("bp_first_valid_timeout", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(12);
    check("bp_all_delivered", 32'(sb.size()), 32'd0);

    // Reset with three operations in flight: none may ever appear.
    ready_mode = 0;
    lat_mode   = 1'b1;
    send(OP_ROL, 16'h0001, 4'd1, 16'h0002, 1'b0);
    send(OP_SLL, 16'h0003, 4'd2, 16'h000C, 1'b0);
    send(OP_SRL, 16'h8000, 4'd3, 16'h1000, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_zero", 32'(out_zero), 32'd1);
    check("midreset_out_err", 32'(out_err), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    idle(8);
    send(OP_ROR, 16'h0001, 4'd4, 16'h1000, 1'b0);
    idle(8);
    check("post_reset_delivered", 32'(sb.size()), 32'd0);

    // Randomised soak with random input gaps and output stalls.
    lat_mode   = 1'b0;
    ready_mode = 1;
    for (int n = 0; n < 10000; n++) begin
      op = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      c  = 4'($urandom_range(0, 15));
      send(op, d, c, model(op, d, int'(c)), (op > OP_ROR));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    in_valid   = 1'b0;
    ready_mode = 0;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("soak_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
